vga_timing_controller: RTL and testbench

- Consumes the 25 MHz pixel strobe produced by the VGA clock generator.
- Generates 640x480@60 Hz VGA timing: horizontal and vertical sync, blanking, and current pixel coordinates (DRAW_X/DRAW_Y) for the colour mapper.
- Also produces line-start and frame-start strobes and a frame counter for sprite/animation logic.
- Runs entirely in the CLOCK_50 domain; the pixel strobe is used as a clock enable, never as a clock.

---
 rtl/vga_timing_controller.sv | 104 ++++++++++
 tb/tb_vga_timing_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_controller.sv
// 640x480@60 VGA timing generator clocked by CLOCK_50; PIX_EN acts as a clock enable.
// Every output is registered from the next-state counters, so sync/blank/strobes line up with DRAW_X/DRAW_Y.
module vga_timing_controller #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       PIX_EN,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic [9:0] DRAW_X,
  output logic [9:0] DRAW_Y,
  output logic       LINE_START,
  output logic       FRAME_START,
  output logic [7:0] FRAME_COUNT
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  // 11-bit bounds so a sync pulse ending exactly at 1024 still compares correctly
  localparam logic [10:0] HS_BEGIN  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEGIN  = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_n_q, blank_n_d;
  logic       line_q, line_d;
  logic       frame_q, frame_d;
  logic [7:0] fcnt_q, fcnt_d;

  always_comb begin
    x_d     = x_q + 10'd1;
    y_d     = y_q;
    line_d  = 1'b0;
    frame_d = 1'b0;
    if (x_q == H_LAST) begin
      x_d    = '0;
      line_d = 1'b1;
      if (y_q == V_LAST) begin
        y_d     = '0;
        frame_d = 1'b1;
      end else begin
        y_d = y_q + 10'd1;
      end
    end
    fcnt_d    = frame_d ? fcnt_q + 8'd1 : fcnt_q;
    hs_d      = !(({1'b0, x_d} >= HS_BEGIN) && ({1'b0, x_d} < HS_END));
    vs_d      = !(({1'b0, y_d} >= VS_BEGIN) && ({1'b0, y_d} < VS_END));
    blank_n_d = ({1'b0, x_d} < H_VIS_END) && ({1'b0, y_d} < V_VIS_END);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      x_q       <= '0;
      y_q       <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b1;
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
      fcnt_q    <= '0;
    end else if (PIX_EN) begin
      x_q       <= x_d;
      y_q       <= y_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      line_q    <= line_d;
      frame_q   <= frame_d;
      fcnt_q    <= fcnt_d;
    end else begin
      // Strobes last exactly one CLOCK_50 cycle even when PIX_EN stalls
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end
  end

  assign DRAW_X      = x_q;
  assign DRAW_Y      = y_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign LINE_START  = line_q;
  assign FRAME_START = frame_q;
  assign FRAME_COUNT = fcnt_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench: default-geometry instance for line timing, small-geometry instance for frame-level timing.
module tb_vga_timing_controller;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst_a_n, pix_en_a;
  logic       hs_a, vs_a, bl_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic [7:0] fc_a;

  logic       rst_b_n, pix_en_b;
  logic       hs_b, vs_b, bl_b, ls_b, fs_b;
  logic [9:0] x_b, y_b;
  logic [7:0] fc_b;

  vga_timing_controller dut_a (
    .CLOCK_50(clk), .RESET_N(rst_a_n), .PIX_EN(pix_en_a),
    .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_N(bl_a),
    .DRAW_X(x_a), .DRAW_Y(y_a), .LINE_START(ls_a),
    .FRAME_START(fs_a), .FRAME_COUNT(fc_a)
  );

  // 16 x 12 geometry: HS low x=10..12, VS low y=8..9, visible x<8, y<6
  vga_timing_controller #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) dut_b (
    .CLOCK_50(clk), .RESET_N(rst_b_n), .PIX_EN(pix_en_b),
    .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK_N(bl_b),
    .DRAW_X(x_b), .DRAW_Y(y_b), .LINE_START(ls_b),
    .FRAME_START(fs_b), .FRAME_COUNT(fc_b)
  );

  task automatic tick_a(input logic en);
    pix_en_a = en;
    @(negedge clk);
  endtask

  task automatic tick_b(input logic en);
    pix_en_b = en;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_a_n = 1'b0; rst_b_n = 1'b0; pix_en_a = 1'b1; pix_en_b = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (x_a !== 10'd0) begin errors++; $display("FAIL rst_draw_x got %0d want 0", x_a); end
    checks++; if (y_a !== 10'd0) begin errors++; $display("FAIL rst_draw_y got %0d want 0", y_a); end
    checks++; if ({hs_a, vs_a, bl_a} !== 3'b111) begin errors++; $display("FAIL rst_hs_vs_blank got %b want 111", {hs_a, vs_a, bl_a}); end
    checks++; if ({ls_a, fs_a} !== 2'b00) begin errors++; $display("FAIL rst_strobes got %b want 00", {ls_a, fs_a}); end
    checks++; if (fc_a !== 8'd0) begin errors++; $display("FAIL rst_frame_count got %0d want 0", fc_a); end
    checks++; if ({x_b, y_b, fc_b} !== 28'd0) begin errors++; $display("FAIL rst_small_counters got %h want 0", {x_b, y_b, fc_b}); end
    rst_a_n = 1'b1; rst_b_n = 1'b1; pix_en_a = 1'b0; pix_en_b = 1'b0;
    tick_a(1'b1);
    checks++; if (x_a !== 10'd1) begin errors++; $display("FAIL first_advance got %0d want 1", x_a); end
    // put instance A back at the origin for the sweep
    rst_a_n = 1'b0; #2 rst_a_n = 1'b1;
    pix_en_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_line_sweep();
    int mx = 0, my = 0;
    int bad_x = 0, bad_y = 0, bad_hs = 0, bad_bl = 0, bad_ls = 0, bad_fs = 0;
    int lines = 0, hs_low = 0;
    logic en, ehs, ebl;
    logic hs655 = 1'b0, hs656 = 1'b1, hs751 = 1'b1, hs752 = 1'b0, bl639 = 1'b0, bl640 = 1'b1;
    for (int i = 0; i < 1600; i++) begin
      en = (i % 2 == 0);
      tick_a(en);
      if (en) begin
        if (mx == 799) begin mx = 0; my = my + 1; end
        else mx = mx + 1;
      end
      ehs = !(mx >= 656 && mx < 752);
      ebl = (mx < 640);
      if (x_a !== 10'(mx)) bad_x++;
      if (y_a !== 10'(my)) bad_y++;
      if (hs_a !== ehs) bad_hs++;
      if (bl_a !== ebl) bad_bl++;
      if (ls_a !== (en && mx == 0)) bad_ls++;
      if (fs_a !== 1'b0) bad_fs++;
      if (ls_a) lines++;
      if (en && !hs_a) hs_low++;
      if (en && mx == 655) hs655 = hs_a;
      if (en && mx == 656) hs656 = hs_a;
      if (en && mx == 751) hs751 = hs_a;
      if (en && mx == 752) hs752 = hs_a;
      if (en && mx == 639) bl639 = bl_a;
      if (en && mx == 640) bl640 = bl_a;
    end
    checks++; if (bad_x != 0) begin errors++; $display("FAIL sweep_x bad_cycles %0d want 0", bad_x); end
    checks++; if (bad_y != 0) begin errors++; $display("FAIL sweep_y bad_cycles %0d want 0", bad_y); end
    checks++; if (bad_hs != 0) begin errors++; $display("FAIL sweep_hs bad_cycles %0d want 0", bad_hs); end
    checks++; if (bad_bl != 0) begin errors++; $display("FAIL sweep_blank bad_cycles %0d want 0", bad_bl); end
    checks++; if (bad_ls != 0) begin errors++; $display("FAIL sweep_line_start bad_cycles %0d want 0", bad_ls); end
    checks++; if (bad_fs != 0) begin errors++; $display("FAIL sweep_frame_start bad_cycles %0d want 0", bad_fs); end
    checks++; if (lines != 1) begin errors++; $display("FAIL sweep_line_pulses got %0d want 1", lines); end
    checks++; if (hs_low != 96) begin errors++; $display("FAIL hs_low_pixels got %0d want 96", hs_low); end
    checks++; if ({hs655, hs656, hs751, hs752} !== 4'b1001) begin errors++; $display("FAIL hs_edges got %b want 1001", {hs655, hs656, hs751, hs752}); end
    checks++; if ({bl639, bl640} !== 2'b10) begin errors++; $display("FAIL blank_edges got %b want 10", {bl639, bl640}); end
    checks++; if (x_a !== 10'd0 || y_a !== 10'd1) begin errors++; $display("FAIL sweep_end got (%0d,%0d) want (0,1)", x_a, y_a); end
    checks++; if (bl_a !== 1'b1) begin errors++; $display("FAIL sweep_end_blank got %b want 1", bl_a); end
  endtask

  task automatic test_freeze();
    logic [33:0] snap;
    int moved = 0, strobes = 0;
    repeat (300) tick_a(1'b1);
    checks++; if (x_a !== 10'd300 || y_a !== 10'd1) begin errors++; $display("FAIL freeze_pos got (%0d,%0d) want (300,1)", x_a, y_a); end
    snap = {hs_a, vs_a, bl_a, ls_a, fs_a, x_a, y_a, fc_a, 1'b0};
    for (int i = 0; i < 100; i++) begin
      tick_a(1'b0);
      if ({hs_a, vs_a, bl_a, ls_a, fs_a, x_a, y_a, fc_a, 1'b0} !== snap) moved++;
      if (ls_a || fs_a) strobes++;
    end
    checks++; if (moved != 0) begin errors++; $display("FAIL freeze_outputs changed_cycles %0d want 0", moved); end
    checks++; if (strobes != 0) begin errors++; $display("FAIL freeze_strobes got %0d want 0", strobes); end
    tick_a(1'b1);
    checks++; if (x_a !== 10'd301) begin errors++; $display("FAIL freeze_resume got %0d want 301", x_a); end
  endtask

  task automatic test_async_reset_a();
    repeat (399) tick_a(1'b1);
    checks++; if (x_a !== 10'd700 || hs_a !== 1'b0 || bl_a !== 1'b0) begin errors++; $display("FAIL pre_reset_a got x=%0d hs=%b bl=%b want 700 0 0", x_a, hs_a, bl_a); end
    #3 rst_a_n = 1'b0;
    #1;
    checks++; if ({x_a, y_a} !== 20'd0 || {hs_a, vs_a, bl_a} !== 3'b111 || fc_a !== 8'd0) begin errors++; $display("FAIL async_reset_a got x=%0d y=%0d hvb=%b fc=%0d want 0 0 111 0", x_a, y_a, {hs_a, vs_a, bl_a}, fc_a); end
    pix_en_a = 1'b0;
    @(negedge clk);
    rst_a_n = 1'b1;
  endtask

  task automatic test_frame();
    int mx = 0, my = 0, fc = 0;
    int bad_pos = 0, bad_hs = 0, bad_vs = 0, bad_bl = 0, bad_ls = 0, bad_fs = 0, bad_fc = 0;
    int frames = 0, vs_rows = 0;
    for (int i = 0; i < 192; i++) begin
      tick_b(1'b1);
      if (mx == 15) begin
        mx = 0;
        if (my == 11) begin my = 0; fc = (fc + 1) % 256; end
        else my = my + 1;
      end else mx = mx + 1;
      if (x_b !== 10'(mx) || y_b !== 10'(my)) bad_pos++;
      if (hs_b !== !(mx >= 10 && mx < 13)) bad_hs++;
      if (vs_b !== !(my >= 8 && my < 10)) bad_vs++;
      if (bl_b !== (mx < 8 && my < 6)) bad_bl++;
      if (ls_b !== (mx == 0)) bad_ls++;
      if (fs_b !== (mx == 0 && my == 0)) bad_fs++;
      if (fc_b !== 8'(fc)) bad_fc++;
      if (fs_b) frames++;
      if (mx == 0 && !vs_b) vs_rows++;
    end
    checks++; if (bad_pos != 0) begin errors++; $display("FAIL frame_pos bad_cycles %0d want 0", bad_pos); end
    checks++; if (bad_hs != 0) begin errors++; $display("FAIL frame_hs bad_cycles %0d want 0", bad_hs); end
    checks++; if (bad_vs != 0) begin errors++; $display("FAIL frame_vs bad_cycles %0d want 0", bad_vs); end
    checks++; if (bad_bl != 0) begin errors++; $display("FAIL frame_blank bad_cycles %0d want 0", bad_bl); end
    checks++; if (bad_ls != 0) begin errors++; $display("FAIL frame_line_start bad_cycles %0d want 0", bad_ls); end
    checks++; if (bad_fs != 0) begin errors++; $display("FAIL frame_start_pulse bad_cycles %0d want 0", bad_fs); end
    checks++; if (bad_fc != 0) begin errors++; $display("FAIL frame_count_track bad_cycles %0d want 0", bad_fc); end
    checks++; if (frames != 1) begin errors++; $display("FAIL frame_pulses got %0d want 1", frames); end
    checks++; if (vs_rows != 2) begin errors++; $display("FAIL vs_rows got %0d want 2", vs_rows); end
    checks++; if ({fs_b, ls_b, fc_b} !== {2'b11, 8'd1}) begin errors++; $display("FAIL frame_end got fs=%b ls=%b fc=%0d want 1 1 1", fs_b, ls_b, fc_b); end
  endtask

  task automatic test_frame_wrap();
    repeat (255 * 192 - 1) tick_b(1'b1);
    checks++; if (fc_b !== 8'd255 || fs_b !== 1'b0 || x_b !== 10'd15 || y_b !== 10'd11) begin errors++; $display("FAIL pre_wrap got fc=%0d fs=%b x=%0d y=%0d want 255 0 15 11", fc_b, fs_b, x_b, y_b); end
    tick_b(1'b1);
    checks++; if (fc_b !== 8'd0 || fs_b !== 1'b1) begin errors++; $display("FAIL count_wrap got fc=%0d fs=%b want 0 1", fc_b, fs_b); end
  endtask

  task automatic test_async_reset_b();
    // FRAME_START is high right now; reset must drop it mid-pulse
    #3 rst_b_n = 1'b0;
    #1;
    checks++; if (fs_b !== 1'b0 || ls_b !== 1'b0) begin errors++; $display("FAIL reset_drops_strobe got fs=%b ls=%b want 0 0", fs_b, ls_b); end
    pix_en_b = 1'b0;
    @(negedge clk);
    rst_b_n = 1'b1;
    repeat (155) tick_b(1'b1);
    checks++; if (x_b !== 10'd11 || y_b !== 10'd9 || {hs_b, vs_b, bl_b} !== 3'b000) begin errors++; $display("FAIL pre_reset_b got x=%0d y=%0d hvb=%b want 11 9 000", x_b, y_b, {hs_b, vs_b, bl_b}); end
    #3 rst_b_n = 1'b0;
    #1;
    checks++; if ({x_b, y_b} !== 20'd0 || {hs_b, vs_b, bl_b} !== 3'b111 || fc_b !== 8'd0) begin errors++; $display("FAIL async_reset_b got x=%0d y=%0d hvb=%b fc=%0d want 0 0 111 0", x_b, y_b, {hs_b, vs_b, bl_b}, fc_b); end
    pix_en_b = 1'b0;
    @(negedge clk);
    rst_b_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_line_sweep();
    test_freeze();
    test_async_reset_a();
    test_frame();
    test_frame_wrap();
    test_async_reset_b();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
